// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op encodings, sequencer states and width default for
//               the MIPS mult/div sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_iter_dp.sv
// ============================================================================
// Module      : muldiv_iter_dp
// Description : Iterative datapath: shift-add multiply, restoring divide and
//               final sign correction of the {Hi, Lo} result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter_dp
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               load,
  input  logic               step,
  input  logic [1:0]         opIn,
  input  logic [WIDTH-1:0]   srcA,
  input  logic [WIDTH-1:0]   srcB,
  output logic [2*WIDTH-1:0] result,
  output logic               divZero
);

  logic             w_signed;
  logic             w_isDiv;
  logic [WIDTH-1:0] w_magA;
  logic [WIDTH-1:0] w_magB;

  // r_mcand holds the multiplicand (mult) or divisor (div) magnitude;
  // r_hi/r_lo hold product halves (mult) or remainder/quotient (div).
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH:0]   r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_isDiv;
  logic             r_negQ;
  logic             r_negR;
  logic             r_divZero;

  logic [WIDTH:0]     w_addSum;
  logic [WIDTH:0]     w_mulT;
  logic [WIDTH:0]     w_shifted;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_hiNext;
  logic [WIDTH-1:0]   w_loNext;
  logic [2*WIDTH-1:0] w_prodMag;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_isDiv  = opIn[1];
  assign w_signed = ~opIn[0];
  assign w_magA   = (w_signed && srcA[WIDTH-1]) ? -srcA : srcA;
  assign w_magB   = (w_signed && srcB[WIDTH-1]) ? -srcB : srcB;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_isDiv   <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_divZero <= 1'b0;
    end else if (load) begin
      r_mcand   <= w_isDiv ? w_magB : w_magA;
      r_lo      <= w_isDiv ? w_magA : w_magB;
      r_hi      <= '0;
      r_isDiv   <= w_isDiv;
      r_negQ    <= w_signed & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
      r_negR    <= w_signed & srcA[WIDTH-1];
      r_divZero <= w_isDiv & (srcB == '0);
    end else if (step) begin
      r_hi <= w_hiNext;
      r_lo <= w_loNext;
    end
  end

  always_comb begin
    w_addSum  = r_hi + {1'b0, r_mcand};
    w_mulT    = r_lo[0] ? w_addSum : r_hi;
    w_shifted = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    w_diff    = w_shifted - {1'b0, r_mcand};
    w_hiNext  = '0;
    w_loNext  = '0;
    if (r_isDiv) begin
      // Borrow out of the trial subtract means the divisor did not fit.
      if (!w_diff[WIDTH]) begin
        w_hiNext = w_diff;
        w_loNext = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hiNext = w_shifted;
        w_loNext = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_hiNext = {1'b0, w_mulT[WIDTH:1]};
      w_loNext = {w_mulT[0], r_lo[WIDTH-1:1]};
    end
  end

  // With a zero divisor the remainder ends as |dividend|, so the remainder
  // sign fix restores the raw dividend for Hi.
  always_comb begin
    w_prodMag = {w_hiNext[WIDTH-1:0], w_loNext};
    w_quo     = w_loNext;
    w_rem     = w_hiNext[WIDTH-1:0];
    result    = '0;
    if (!r_isDiv) begin
      result = r_negQ ? -w_prodMag : w_prodMag;
    end else begin
      result[WIDTH-1:0]       = r_divZero ? '1 : (r_negQ ? -w_quo : w_quo);
      result[2*WIDTH-1:WIDTH] = r_negR ? -w_rem : w_rem;
    end
  end

  assign divZero = r_divZero;

endmodule

`default_nettype wire

// File: rtl/muldiv_seq_ctrl.sv
// ============================================================================
// Module      : muldiv_seq_ctrl
// Description : E-stage mult/div sequencer: stalls the pipe while iterating,
//               then pulses the Lo/Hi write toward the E/M register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               StartE,
  input  logic [1:0]         OpE,
  input  logic [WIDTH-1:0]   SrcAE,
  input  logic [WIDTH-1:0]   SrcBE,
  input  logic               FlushE,
  output logic               StallE,
  output logic               WriteLoHiE,
  output logic [2*WIDTH-1:0] loHi_dataE,
  output logic               DivZeroE
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             r_state;
  state_t             w_stateNext;
  logic [CNT_W-1:0]   r_count;
  logic               w_load;
  logic               w_step;
  logic               w_final;
  logic [2*WIDTH-1:0] w_result;
  logic               w_divZero;

  muldiv_iter_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .CLK     (CLK),
    .RST     (RST),
    .load    (w_load),
    .step    (w_step),
    .opIn    (OpE),
    .srcA    (SrcAE),
    .srcB    (SrcBE),
    .result  (w_result),
    .divZero (w_divZero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_load) begin
        r_count <= '0;
      end else if (w_step) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // Flush takes priority over the final iteration, so a squashed op never writes.
  always_comb begin
    w_stateNext = r_state;
    StallE      = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_final     = 1'b0;
    case (r_state)
      IDLE: begin
        if (StartE && !FlushE) begin
          StallE      = 1'b1;
          w_load      = 1'b1;
          w_stateNext = RUN;
        end
      end
      RUN: begin
        StallE = 1'b1;
        if (FlushE) begin
          w_stateNext = IDLE;
        end else begin
          w_step = 1'b1;
          if (r_count == CNT_W'(WIDTH - 1)) begin
            w_final     = 1'b1;
            w_stateNext = DONE;
          end
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      loHi_dataE <= '0;
    end else if (w_final) begin
      loHi_dataE <= w_result;
    end
  end

  assign WriteLoHiE = (r_state == DONE);
  assign DivZeroE   = (r_state == DONE) & w_divZero;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq_ctrl.sv
// ============================================================================
// Module      : tb_muldiv_seq_ctrl
// Description : Scoreboard bench for muldiv_seq_ctrl with an arithmetic
//               reference model and randomized operations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_seq_ctrl;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          StartE = 1'b0;
  logic [1:0]    OpE = 2'b00;
  logic [W-1:0]  SrcAE = '0;
  logic [W-1:0]  SrcBE = '0;
  logic          FlushE = 1'b0;
  logic          StallE;
  logic          WriteLoHiE;
  logic [2*W-1:0] loHi_dataE;
  logic          DivZeroE;

  int nCompared   = 0;
  int nMismatched = 0;
  logic [64:0]    expQ[$];
  logic [2*W-1:0] lastResult = '0;

  muldiv_seq_ctrl #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .StartE     (StartE),
    .OpE        (OpE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .FlushE     (FlushE),
    .StallE     (StallE),
    .WriteLoHiE (WriteLoHiE),
    .loHi_dataE (loHi_dataE),
    .DivZeroE   (DivZeroE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: MIPS semantics from plain integer arithmetic; returns {divZero, Hi, Lo}.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, prod;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: begin
        q = sa * sb;
        return {1'b0, q[63:0]};
      end
      2'b01: begin
        prod = ua * ub;
        return {1'b0, prod};
      end
      2'b10: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        prod = ua / ub;
        ua   = ua % ub;
        return {1'b0, ua[31:0], prod[31:0]};
      end
    endcase
  endfunction

  // Issues one op at c0 and checks stall timing; flushAt < 0 means run to completion.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int flushAt);
    logic [64:0] m;
    m = model(op, a, b);
    @(posedge CLK); #1;
    StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b; FlushE = 1'b0;
    if (flushAt < 0) expQ.push_back(m);
    for (int c = 0; c <= W; c++) begin
      if (c == flushAt) FlushE = 1'b1;
      @(negedge CLK);
      check($sformatf("stall_c%0d", c), StallE, 1);
      check("nowrite_run", WriteLoHiE, 0);
      @(posedge CLK); #1;
      if (c == flushAt) begin
        FlushE = 1'b0; StartE = 1'b0;
        @(negedge CLK);
        check("flush_idle_stall", StallE, 0);
        check("flush_hold_lohi", loHi_dataE, lastResult);
        return;
      end
    end
    @(negedge CLK);
    check("done_stall", StallE, 0);
    check("done_write", WriteLoHiE, 1);
    lastResult = m[63:0];
  endtask

  task automatic go_idle(input int n);
    @(posedge CLK); #1;
    StartE = 1'b0; FlushE = 1'b0;
    repeat (n) begin
      @(negedge CLK);
      check("idle_stall", StallE, 0);
      check("idle_write", WriteLoHiE, 0);
      check("idle_hold_lohi", loHi_dataE, lastResult);
      @(posedge CLK); #1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin : monitor
    logic [64:0] e;
    forever begin
      @(negedge CLK);
      if (WriteLoHiE) begin
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("FAIL unexpected_write: got write of %h, expected no write at %0t", loHi_dataE, $time);
        end else begin
          e = expQ.pop_front();
          check("result", {DivZeroE, loHi_dataE}, e);
        end
      end else begin
        check("divzero_quiet", DivZeroE, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset_stall", StallE, 0);
    check("reset_write", WriteLoHiE, 0);
    check("reset_divzero", DivZeroE, 0);
    check("reset_lohi", loHi_dataE, 0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1); go_idle(1);
    run_op(2'b00, -32'd3, 32'd5, -1);                go_idle(1);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1); go_idle(1);
    run_op(2'b10, -32'd7, 32'd2, -1);                go_idle(1);
    run_op(2'b11, 32'd100, 32'd7, -1);               go_idle(1);
    run_op(2'b11, 32'd100, 32'd0, -1);               go_idle(1);
    run_op(2'b10, -32'd100, 32'd0, -1);              go_idle(1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1); go_idle(1);

    // Squashed MULTU must leave Lo/Hi untouched.
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    go_idle(3);

    // Start with flush in IDLE must not begin an operation.
    @(posedge CLK); #1;
    StartE = 1'b1; FlushE = 1'b1; OpE = 2'b01; SrcAE = 32'd3; SrcBE = 32'd4;
    @(negedge CLK);
    check("start_flush_stall", StallE, 0);
    go_idle(2);

    // Reset in the middle of a DIV aborts it with no write.
    @(posedge CLK); #1;
    StartE = 1'b1; OpE = 2'b10; SrcAE = 32'd1000; SrcBE = 32'd7; FlushE = 1'b0;
    repeat (5) begin @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; StartE = 1'b0;
    @(negedge CLK);
    check("midrst_stall", StallE, 0);
    check("midrst_write", WriteLoHiE, 0);
    check("midrst_divzero", DivZeroE, 0);
    check("midrst_lohi", loHi_dataE, 0);
    lastResult = '0;
    run_op(2'b11, 32'd9, 32'd3, -1);
    go_idle(1);

    // StartE held through DONE; a new op issued straight after DONE.
    run_op(2'b00, 32'd12345, -32'd678, -1);
    run_op(2'b11, 32'hDEAD_BEEF, 32'd17, -1);
    go_idle(2);

    for (int i = 0; i < 20; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      if ($urandom_range(0, 4) == 0) begin
        run_op(op, a, b, int'($urandom_range(0, W)));
        go_idle(1);
      end else begin
        run_op(op, a, b, -1);
        if ($urandom_range(0, 1) == 1) go_idle(1);
      end
    end
    go_idle(3);
    check("queue_drained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU in the Execute stage.
- Runs an iterative shift-add multiplier and a restoring divider over WIDTH cycles.
- Stalls F/D/E while it iterates, then presents WriteLoHiE and loHi_dataE for one cycle so the E/M pipeline register captures the Lo/Hi write.
- Sits between the decoded E-stage controls and the E/M pipeline register inputs; the hazard unit consumes StallE.

Parameters:
- WIDTH, 32, operand width; count register is $clog2(WIDTH)+1 bits.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  synchronous, active-high reset
- StartE  input  1  mult/div instruction present in E (held by stall)
- OpE  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- SrcAE  input  WIDTH  rs operand (dividend / multiplicand)
- SrcBE  input  WIDTH  rt operand (divisor / multiplier)
- FlushE  input  1  squash the E-stage instruction
- StallE  output  1  hold F/D/E; bubble into E/M
- WriteLoHiE  output  1  one-cycle Lo/Hi write enable toward E/M
- loHi_dataE  output  2*WIDTH  {Hi, Lo}: [63:32]=Hi, [31:0]=Lo
- DivZeroE  output  1  one-cycle flag: divide by zero

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- RST: state=IDLE, count=0, all datapath registers 0. Outputs reset to WriteLoHiE=0, DivZeroE=0, loHi_dataE=0, StallE=0. RST mid-operation aborts the operation with no Lo/Hi write.
- States:
  - IDLE: StallE = StartE & ~FlushE (combinational). On an edge with StartE & ~FlushE:
    - Latch operands as magnitudes for signed ops and unsigned values otherwise.
    - Latch the result signs: product sign = A xor B; quotient sign = A xor B; remainder sign = A.
    - Clear the accumulator and set count=0, then go to RUN.
  - RUN: StallE=1. Perform one iteration per cycle and increment count.
    - When count==WIDTH-1, the edge performs the final iteration plus sign correction (two's-complement negate of the 64-bit product, or of quotient and remainder separately), registers the result into loHi_dataE, and goes to DONE.
    - FlushE in RUN: the next edge goes to IDLE with no write and loHi_dataE unchanged. StallE stays 1 during the flush cycle.
  - DONE: StallE=0, WriteLoHiE=1, DivZeroE=1 if the operation was a div with divisor 0. StartE is ignored in this state, because it is the same instruction leaving E. Next edge goes to IDLE.
- Latency: start cycle c0 plus WIDTH RUN cycles gives StallE high for WIDTH+1 cycles (c0..c32). DONE is at c0+WIDTH+1.
- loHi_dataE is registered and holds its value until the next completion.
- Multiply: unsigned shift-add, one multiplier bit per cycle, 64-bit product.
- Divide: restoring algorithm, one quotient bit per cycle. Lo = quotient, Hi = remainder.
- Divide by zero:
  - Result is Lo = all ones and Hi = dividend (the raw latched SrcAE), with no sign correction.
  - DivZeroE pulses in DONE.
  - No trap.
- Edge cases:
  - MULT/DIV of the most-negative value: magnitude 0x80000000 is handled as unsigned and results are exact. DIV 0x80000000 / -1 gives Lo=0x80000000, Hi=0.
  - StartE with FlushE in IDLE: no start, StallE=0.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state enum IDLE/RUN/DONE;
  - WIDTH default.
- One sub-module, muldiv_iter_dp: the operand, accumulator, shift and subtract datapath, plus sign fix. The FSM, count and outputs live in muldiv_seq_ctrl.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at c0:
  - StallE high c0..c32.
  - c33: WriteLoHiE=1, loHi_dataE=0xFFFFFFFE_00000001.
  - c34: WriteLoHiE=0, StallE=0.
- MULT -3 × 5: loHi_dataE=0xFFFFFFFF_FFFFFFF1. MULT 0x80000000 × 0x80000000: loHi_dataE=0x40000000_00000000.
- DIV -7 / 2: Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 100 / 7: Lo=14, Hi=2.
- DIVU 100 / 0: Lo=0xFFFFFFFF, Hi=0x00000064, DivZeroE=1 for exactly the DONE cycle.
- FlushE at c10 of a MULTU:
  - c11: IDLE, StallE=0.
  - No WriteLoHiE pulse ever; loHi_dataE keeps its previous value.
- RST at c5 of a DIV: state IDLE, all outputs 0 the next cycle. Then start a DIVU 9 / 3: Lo=3, Hi=0 at c+33. Also check back-to-back starts (StartE held through DONE does not restart).
